seven_seg_scan_driver: RTL and testbench

- Consumes the 32-bit DISP_NUM word produced by the bus-mapped seven-segment register device.
- Drives the board's 8-digit, common-anode, time-multiplexed seven-segment display.
- Latches the number once per frame so the display never tears mid-frame.
- Scans the digits with a programmable dwell time and inserts an anti-ghosting blank at the start of each digit slot.

---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_hex_decoder.sv | 31 +++
 rtl/seven_seg_scan_driver.sv | 85 ++++++++
 tb/tb_seven_seg_scan_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// Segment codes are active-low patterns for seg[6:0] = g,f,e,d,c,b,a.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Index of the most significant nonzero nibble; 0 when the word is zero.
  function automatic logic [2:0] msd_index(input logic [31:0] num);
    logic [2:0] m;
    m = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (num[4*k +: 4] != 4'h0) m = 3'(k);
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_0;
    unique case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// 8-digit common-anode scan driver with per-frame latch and anti-ghost blanking.
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GHOST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_num,
  input  logic [7:0]  dp_in,
  input  logic        en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GHOST_LIM = CW'(GHOST_CYCLES);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [31:0]   shadow_num;
  logic [7:0]    shadow_dp;
  logic [6:0]    seg_code;
  logic          in_ghost;
  logic          lz_blank;

  seven_seg_hex_decoder u_dec (
    .nibble  (shadow_num[4*idx +: 4]),
    .pattern (seg_code)
  );

  if (GHOST_CYCLES > 0) begin : g_ghost
    assign in_ghost = (cnt < GHOST_LIM);
  end else begin : g_no_ghost
    assign in_ghost = 1'b0;
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx > msd_index(shadow_num));
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_num <= '0;
      shadow_dp  <= '0;
      an         <= AN_NONE;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (idx == IDX_LAST) && (cnt == CNT_LAST);

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Latch once at the top of each frame so a frame never mixes two values.
      if (idx == '0 && cnt == '0) begin
        shadow_num <= disp_num;
        shadow_dp  <= dp_in;
      end

      if (!en || in_ghost || lz_blank) begin
        an  <= AN_NONE;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(8'h01 << idx);
        seg <= {~shadow_dp[idx], seg_code};
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed plus random stimulus against a cycle-count reference model of the scan driver.
module tb_seven_seg_scan_driver;

  localparam int DC    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 8 * DC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] disp_num;
  logic [7:0]  dp_in;
  logic        en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.DIGIT_CYCLES(DC), .GHOST_CYCLES(GC)) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_num   (disp_num),
    .dp_in      (dp_in),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  int          checks   = 0;
  int          failures = 0;
  int          t        = 0;
  int          cyc      = 0;
  int          last_fd  = -1;
  logic [31:0] mshadow  = '0;
  logic [7:0]  mdp      = '0;
  logic [6:0]  hex_tab [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Model: t counts cycles since reset release; digit = (t/DC)%8, position in slot = t%DC.
  task automatic step();
    logic [7:0] ean, eseg;
    logic       efd, show;
    int         d, pos, m;
    ean = 8'hFF; eseg = 8'hFF; efd = 1'b0;
    if (!reset) begin
      d   = (t / DC) % 8;
      pos = t % DC;
      m   = 0;
      for (int k = 7; k >= 1; k--)
        if (m == 0 && (mshadow >> (4 * k)) != 0) m = k;
      efd  = (t % FRAME) == FRAME - 1;
      show = en && (pos >= GC);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (d > m) show = 1'b0;
`endif
      if (show) begin
        ean  = 8'hFF ^ (8'(1) << d);
        eseg = {~mdp[d], hex_tab[(mshadow >> (4 * d)) & 32'hF]};
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("an", an, ean);
    chk("seg", seg, eseg);
    chk("frame_done", {7'd0, frame_done}, {7'd0, efd});
    checks++;
    assert ($countones(~an) <= 1) else begin
      failures++;
      $error("FAIL anode_onehot observed=%h expected=at_most_one_low cycle=%0d", an, cyc);
    end
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) begin
        checks++;
        assert (cyc - last_fd == FRAME) else begin
          failures++;
          $error("FAIL fd_spacing observed=%0d expected=%0d cycle=%0d", cyc - last_fd, FRAME, cyc);
        end
      end
      last_fd = cyc;
    end
    if (reset) begin
      t = 0; mshadow = '0; mdp = '0; last_fd = -1;
    end else begin
      if (t % FRAME == 0) begin
        mshadow = disp_num;
        mdp     = dp_in;
      end
      t++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the model sits at a given offset within the frame (bounded).
  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != target; i++) step();
    checks++;
    assert ((t % FRAME) == target) else begin
      failures++;
      $error("FAIL run_to observed=%0d expected=%0d cycle=%0d", t % FRAME, target, cyc);
    end
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset    = 1'b1;
    en       = 1'b1;
    disp_num = 32'h0123ABEF;
    dp_in    = 8'h00;
    run(3);
    reset = 1'b0;
    run(2 * FRAME);

    // Change lands in slot 3; old digits must persist until the next frame.
    run_to(3 * DC + 4);
    disp_num = 32'hFFFFFFFF;
    run(FRAME + 8);

    dp_in = 8'h04;
    disp_num = 32'h89CD4567;
    run(2 * FRAME);
    dp_in = 8'h00;

    // Blank from mid slot 2, re-enable mid slot 5 with no resync.
    run_to(2 * DC + 3);
    en = 1'b0;
    run_to(5 * DC + 3);
    en = 1'b1;
    run(FRAME);

    disp_num = 32'h00000050;
    run(2 * FRAME);
    disp_num = 32'h00000000;
    run(2 * FRAME);

    // Reset in the middle of a scan restarts at digit 0.
    disp_num = 32'h76543210;
    run_to(4 * DC + 5);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(FRAME + 4);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0)
        disp_num = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(7)));
      if ($urandom_range(9) == 0) dp_in = 8'($urandom);
      if ($urandom_range(39) == 0) en = ~en;
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;
    en    = 1'b1;
    run(FRAME + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
